// File: rtl/ysyx_2022040010_sram_resp.sv
// Single-cycle SRAM model with an instruction read port and a data load/store
// port sharing one 64-bit-wide memory, plus sticky first-error capture.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   isram_e/addr        instruction fetch request and byte address
//   isram_rdata         fetched 32-bit instruction (registered, nop on error)
//   dsram_e/we/addr     data request, store enable, byte address
//   dsram_wdata/sel     right-justified store data, one-hot access size
//   dsram_rdata         aligned 64-bit word for loads (registered)
//   err/err_code/addr   sticky first error: 01 range, 10 misaligned, 11 bad sel
module ysyx_2022040010_sram_resp #(
  parameter logic [63:0] BASE  = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isram_e,
  input  logic [63:0] isram_addr,
  output logic [31:0] isram_rdata,
  input  logic        dsram_e,
  input  logic        dsram_we,
  input  logic [63:0] dsram_addr,
  input  logic [63:0] dsram_wdata,
  input  logic [3:0]  dsram_sel,
  output logic [63:0] dsram_rdata,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [63:0] err_addr
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) << 3;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_RANGE = 2'b01;
  localparam logic [1:0] E_ALIGN = 2'b10;
  localparam logic [1:0] E_SEL   = 2'b11;

  logic [63:0] mem [DEPTH];

  // Fetch-side decode
  logic [63:0]   i_off_c;
  logic [AW-1:0] i_idx_c;
  logic [63:0]   i_word_c;
  logic [1:0]    i_code_c;

  always_comb begin
    i_off_c  = isram_addr - BASE;
    i_idx_c  = i_off_c[AW+2:3];
    i_word_c = mem[i_idx_c];
    i_code_c = E_NONE;
    if ((isram_addr < BASE) || (i_off_c >= SPAN)) begin
      i_code_c = E_RANGE;
    end else if (isram_addr[1:0] != 2'b00) begin
      i_code_c = E_ALIGN;
    end
  end

  // Data-side decode: size, alignment, byte lanes and shifted store data
  logic [63:0]   d_off_c;
  logic [AW-1:0] d_idx_c;
  logic          d_oor_c;
  logic          d_bad_c;
  logic          d_mis_c;
  logic [7:0]    d_be_c;
  logic [7:0]    d_be_sh_c;
  logic [63:0]   d_mask_c;
  logic [63:0]   d_wsh_c;
  logic [1:0]    d_code_c;
  logic          d_wr_c;
  logic          d_rd_ok_c;

  always_comb begin
    d_off_c   = dsram_addr - BASE;
    d_idx_c   = d_off_c[AW+2:3];
    d_oor_c   = (dsram_addr < BASE) || (d_off_c >= SPAN);
    d_bad_c   = 1'b0;
    d_mis_c   = 1'b0;
    d_be_c    = 8'h00;
    d_mask_c  = 64'h0;
    d_code_c  = E_NONE;
    case (dsram_sel)
      4'b0001: d_be_c = 8'h01;
      4'b0010: begin d_be_c = 8'h03; d_mis_c = dsram_addr[0];       end
      4'b0100: begin d_be_c = 8'h0F; d_mis_c = |dsram_addr[1:0];    end
      4'b1000: begin d_be_c = 8'hFF; d_mis_c = |dsram_addr[2:0];    end
      default: d_bad_c = 1'b1;
    endcase
    d_be_sh_c = d_be_c << dsram_addr[2:0];
    for (int b = 0; b < 8; b++) begin
      d_mask_c[8*b +: 8] = {8{d_be_sh_c[b]}};
    end
    d_wsh_c = dsram_wdata << {dsram_addr[2:0], 3'b000};
    if (d_oor_c) begin
      d_code_c = E_RANGE;
    end else if (d_bad_c) begin
      d_code_c = E_SEL;
    end else if (d_mis_c) begin
      d_code_c = E_ALIGN;
    end
    d_wr_c    = dsram_e && dsram_we && (d_code_c == E_NONE);
    // A misaligned load still returns the aligned word
    d_rd_ok_c = !d_oor_c && !d_bad_c;
  end

  // Memory array is never reset; writes are masked while reset is held
  always_ff @(posedge clk) begin
    if (rst && d_wr_c) begin
      mem[d_idx_c] <= (mem[d_idx_c] & ~d_mask_c) | (d_wsh_c & d_mask_c);
    end
  end

  // Read data and sticky error registers; reads see pre-store contents
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      isram_rdata <= NOP;
      dsram_rdata <= 64'h0;
      err         <= 1'b0;
      err_code    <= E_NONE;
      err_addr    <= 64'h0;
    end else begin
      if (isram_e) begin
        if (i_code_c != E_NONE) begin
          isram_rdata <= NOP;
        end else begin
          isram_rdata <= isram_addr[2] ? i_word_c[63:32] : i_word_c[31:0];
        end
      end
      if (dsram_e && !dsram_we) begin
        dsram_rdata <= d_rd_ok_c ? mem[d_idx_c] : 64'h0;
      end
      // Data-port error wins over a fetch error on the same edge
      if (!err) begin
        if (dsram_e && (d_code_c != E_NONE)) begin
          err      <= 1'b1;
          err_code <= d_code_c;
          err_addr <= dsram_addr;
        end else if (isram_e && (i_code_c != E_NONE)) begin
          err      <= 1'b1;
          err_code <= i_code_c;
          err_addr <= isram_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_2022040010_sram_resp.sv
// Directed bench for ysyx_2022040010_sram_resp: a vector table for the main
// store/load/fetch flow plus short sequences around reset and error priority.
module tb_ysyx_2022040010_sram_resp;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        isram_e;
  logic [63:0] isram_addr;
  logic [31:0] isram_rdata;
  logic        dsram_e;
  logic        dsram_we;
  logic [63:0] dsram_addr;
  logic [63:0] dsram_wdata;
  logic [3:0]  dsram_sel;
  logic [63:0] dsram_rdata;
  logic        err;
  logic [1:0]  err_code;
  logic [63:0] err_addr;

  ysyx_2022040010_sram_resp dut (
    .clk(clk), .rst(rst),
    .isram_e(isram_e), .isram_addr(isram_addr), .isram_rdata(isram_rdata),
    .dsram_e(dsram_e), .dsram_we(dsram_we), .dsram_addr(dsram_addr),
    .dsram_wdata(dsram_wdata), .dsram_sel(dsram_sel), .dsram_rdata(dsram_rdata),
    .err(err), .err_code(err_code), .err_addr(err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        ie;
    logic [63:0] ia;
    logic        de;
    logic        dwe;
    logic [63:0] da;
    logic [63:0] wd;
    logic [3:0]  sel;
    logic [31:0] ei;
    logic [63:0] ed;
    logic        eerr;
    logic [1:0]  ecode;
    logic [63:0] eaddr;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [31:0] ei, input logic [63:0] ed,
                         input logic eerr, input logic [1:0] ecode, input logic [63:0] eaddr);
    chk({name, ".isram_rdata"}, 64'(isram_rdata), 64'(ei));
    chk({name, ".dsram_rdata"}, dsram_rdata, ed);
    chk({name, ".err"},         64'(err), 64'(eerr));
    chk({name, ".err_code"},    64'(err_code), 64'(ecode));
    chk({name, ".err_addr"},    err_addr, eaddr);
  endtask

  task automatic drive(input logic ie, input logic [63:0] ia, input logic de, input logic dwe,
                       input logic [63:0] da, input logic [63:0] wd, input logic [3:0] sel);
    isram_e = ie; isram_addr = ia;
    dsram_e = de; dsram_we = dwe; dsram_addr = da; dsram_wdata = wd; dsram_sel = sel;
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 4'b0000);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    idle();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
  endtask

  function automatic vec_t mk(input logic ie, input logic [63:0] ia, input logic de,
                              input logic dwe, input logic [63:0] da, input logic [63:0] wd,
                              input logic [3:0] sel, input logic [31:0] ei, input logic [63:0] ed,
                              input logic eerr, input logic [1:0] ecode, input logic [63:0] eaddr);
    vec_t v;
    v.ie = ie; v.ia = ia; v.de = de; v.dwe = dwe; v.da = da; v.wd = wd; v.sel = sel;
    v.ei = ei; v.ed = ed; v.eerr = eerr; v.ecode = ecode; v.eaddr = eaddr;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ie ia          de dwe da           wd                     sel      | ei           ed                     err code eaddr
    tbl[0]  = mk(0, 64'h0,    1, 1, B+64'h10, 64'h1122334455667788, 4'b1000, 32'h00000013, 64'h0,                 0, 2'b00, 64'h0);
    tbl[1]  = mk(0, 64'h0,    1, 0, B+64'h10, 64'h0,                4'b1000, 32'h00000013, 64'h1122334455667788, 0, 2'b00, 64'h0);
    tbl[2]  = mk(0, 64'h0,    1, 1, B+64'h13, 64'hAB,               4'b0001, 32'h00000013, 64'h1122334455667788, 0, 2'b00, 64'h0);
    tbl[3]  = mk(1, B+64'h14, 1, 0, B+64'h10, 64'h0,                4'b0100, 32'h11223344, 64'h11223344AB667788, 0, 2'b00, 64'h0);
    tbl[4]  = mk(0, 64'h0,    1, 1, B+64'h11, 64'hFFFF,             4'b0010, 32'h11223344, 64'h11223344AB667788, 1, 2'b10, B+64'h11);
    tbl[5]  = mk(0, 64'h0,    1, 0, B+64'h10, 64'h0,                4'b1000, 32'h11223344, 64'h11223344AB667788, 1, 2'b10, B+64'h11);
    tbl[6]  = mk(0, 64'h0,    1, 0, B+64'h8000, 64'h0,              4'b1000, 32'h11223344, 64'h0,                 1, 2'b10, B+64'h11);
    tbl[7]  = mk(0, 64'h0,    0, 0, B+64'h10, 64'h0,                4'b1000, 32'h11223344, 64'h0,                 1, 2'b10, B+64'h11);
    tbl[8]  = mk(0, 64'h0,    1, 0, B+64'h10, 64'h0,                4'b0000, 32'h11223344, 64'h0,                 1, 2'b10, B+64'h11);
    tbl[9]  = mk(0, 64'h0,    1, 1, B+64'h20, 64'h0123456789ABCDEF, 4'b1000, 32'h11223344, 64'h0,                 1, 2'b10, B+64'h11);
    tbl[10] = mk(1, B+64'h20, 1, 1, B+64'h20, 64'hDEADBEEF,         4'b0100, 32'h89ABCDEF, 64'h0,                 1, 2'b10, B+64'h11);
    tbl[11] = mk(1, B+64'h20, 1, 0, B+64'h20, 64'h0,                4'b1000, 32'hDEADBEEF, 64'h01234567DEADBEEF, 1, 2'b10, B+64'h11);
    tbl[12] = mk(1, B+64'h24, 0, 0, 64'h0,    64'h0,                4'b0000, 32'h01234567, 64'h01234567DEADBEEF, 1, 2'b10, B+64'h11);
    tbl[13] = mk(1, B+64'h22, 0, 0, 64'h0,    64'h0,                4'b0000, 32'h00000013, 64'h01234567DEADBEEF, 1, 2'b10, B+64'h11);
    tbl[14] = mk(0, 64'h0,    1, 1, B+64'h27, 64'h5A,               4'b0001, 32'h00000013, 64'h01234567DEADBEEF, 1, 2'b10, B+64'h11);
    tbl[15] = mk(0, 64'h0,    1, 0, B+64'h20, 64'h0,                4'b1000, 32'h00000013, 64'h5A234567DEADBEEF, 1, 2'b10, B+64'h11);
    tbl[16] = mk(0, 64'h0,    1, 1, B+64'h26, 64'hCAFE,             4'b0010, 32'h00000013, 64'h5A234567DEADBEEF, 1, 2'b10, B+64'h11);
    tbl[17] = mk(0, 64'h0,    1, 0, B+64'h20, 64'h0,                4'b1000, 32'h00000013, 64'hCAFE4567DEADBEEF, 1, 2'b10, B+64'h11);

    // Reset values while reset is held
    rst = 1'b1;
    idle();
    #2 rst = 1'b0;
    #1 chk_all("reset", 32'h13, 64'h0, 1'b0, 2'b00, 64'h0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].ie, tbl[i].ia, tbl[i].de, tbl[i].dwe, tbl[i].da, tbl[i].wd, tbl[i].sel);
      cycle();
      chk_all($sformatf("vec%0d", i), tbl[i].ei, tbl[i].ed, tbl[i].eerr, tbl[i].ecode, tbl[i].eaddr);
    end

    // Mid-access reset: outputs clear at once, store under reset is dropped
    drive(1'b1, B+64'h10, 1'b1, 1'b0, B+64'h20, 64'h0, 4'b1000);
    #2 rst = 1'b0;
    #1 chk_all("rst_async", 32'h13, 64'h0, 1'b0, 2'b00, 64'h0);
    drive(1'b0, 64'h0, 1'b1, 1'b1, B+64'h10, 64'h0, 4'b1000);
    cycle();
    chk_all("rst_hold", 32'h13, 64'h0, 1'b0, 2'b00, 64'h0);
    @(negedge clk) rst = 1'b1;
    drive(1'b0, 64'h0, 1'b1, 1'b0, B+64'h10, 64'h0, 4'b1000);
    cycle();
    chk_all("post_rst_load", 32'h13, 64'h11223344AB667788, 1'b0, 2'b00, 64'h0);

    // Fetch below BASE
    drive(1'b1, B-64'h4, 1'b0, 1'b0, 64'h0, 64'h0, 4'b0000);
    cycle();
    chk_all("fetch_oor", 32'h13, 64'h11223344AB667788, 1'b1, 2'b01, B-64'h4);

    // Good fetch plus bad-sel load: err stays sticky at the first cause
    drive(1'b1, B+64'h10, 1'b1, 1'b0, B+64'h10, 64'h0, 4'b0011);
    cycle();
    chk_all("sticky", 32'hAB667788, 64'h0, 1'b1, 2'b01, B-64'h4);

    // Same-edge data error outranks fetch error
    rst_pulse();
    drive(1'b1, B-64'h4, 1'b1, 1'b0, B+64'h10, 64'h0, 4'b0000);
    cycle();
    chk_all("prio_port", 32'h13, 64'h0, 1'b1, 2'b11, B+64'h10);

    // Out-of-range outranks bad sel
    rst_pulse();
    drive(1'b0, 64'h0, 1'b1, 1'b0, B+64'h8000, 64'h0, 4'b0011);
    cycle();
    chk_all("prio_oor", 32'h13, 64'h0, 1'b1, 2'b01, B+64'h8000);

    // Misaligned load returns the aligned word and flags alignment
    rst_pulse();
    drive(1'b0, 64'h0, 1'b1, 1'b0, B+64'h12, 64'h0, 4'b0100);
    cycle();
    chk_all("mis_load", 32'h13, 64'h11223344AB667788, 1'b1, 2'b10, B+64'h12);

    // Out-of-range store must not alias into the array
    rst_pulse();
    drive(1'b0, 64'h0, 1'b1, 1'b1, B, 64'hA5A5A5A5A5A5A5A5, 4'b1000);
    cycle();
    drive(1'b0, 64'h0, 1'b1, 1'b1, B+64'h8000, 64'hFFFFFFFFFFFFFFFF, 4'b1000);
    cycle();
    drive(1'b0, 64'h0, 1'b1, 1'b0, B, 64'h0, 4'b1000);
    cycle();
    chk_all("oor_store", 32'h13, 64'hA5A5A5A5A5A5A5A5, 1'b1, 2'b01, B+64'h8000);

    idle();
    cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_2022040010_sram_resp.md
YSYX_2022040010_SRAM_RESP -- requirements
Module: ysyx_2022040010_sram_resp

Interface
REQ-001 Parameter BASE, default 64'h0000_0000_8000_0000, byte address of memory word 0.
REQ-002 Parameter DEPTH, default 4096, number of 64-bit words; power of two.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-low.
REQ-005 isram_e  input  1  instruction read request.
REQ-006 isram_addr  input  64  instruction byte address.
REQ-007 isram_rdata  output  32  instruction word; registered.
REQ-008 dsram_e  input  1  data access request.
REQ-009 dsram_we  input  1  1 = store, 0 = load; valid when dsram_e=1.
REQ-010 dsram_addr  input  64  data byte address.
REQ-011 dsram_wdata  input  64  store data, right-justified (bits [8n-1:0] for n-byte store).
REQ-012 dsram_sel  input  4  one-hot access size: 0001 byte, 0010 half, 0100 word, 1000 dword.
REQ-013 dsram_rdata  output  64  aligned 64-bit word containing the load address; registered.
REQ-014 err  output  1  sticky error flag.
REQ-015 err_code  output  2  first-error cause: 01 out-of-range, 10 misaligned, 11 bad sel.
REQ-016 err_addr  output  64  byte address of first error.

Function
REQ-017 Index = (addr - BASE) >> 3; an access is in range iff BASE <= addr < BASE + 8*DEPTH.
REQ-018 Instruction read: on an edge with isram_e=1, isram_rdata SHALL load mem[index] bits [63:32] if isram_addr[2]=1, else bits [31:0]; one-cycle latency.
REQ-019 isram_e=0 SHALL hold isram_rdata unchanged.
REQ-020 Instruction fetch out of range or with isram_addr[1:0]!=0 SHALL load isram_rdata=32'h0000_0013 (nop) and record an error per REQ-026.
REQ-021 Data load: on an edge with dsram_e=1, dsram_we=0, dsram_rdata SHALL load the full aligned word mem[index]; lane extraction is not this block's job; one-cycle latency.
REQ-022 Data store: on an edge with dsram_e=1, dsram_we=1, the bytes selected by the size (1/2/4/8) starting at offset addr[2:0] SHALL be written from dsram_wdata low bytes shifted by 8*addr[2:0]; all other bytes unchanged.
REQ-023 Store cycles SHALL hold dsram_rdata unchanged; dsram_e=0 SHALL hold dsram_rdata unchanged.
REQ-024 Alignment: addr[2:0] SHALL be a multiple of the access size; misaligned store is suppressed, misaligned load returns the aligned word.
REQ-025 dsram_sel not one-hot (including 0000): access suppressed (load returns 0); out-of-range load returns 64'h0 and out-of-range store is suppressed.
REQ-026 Error capture: the first error after reset sets err=1 and loads err_code/err_addr; later errors SHALL NOT change them until reset. Priority: out-of-range > bad sel > misaligned. A data-port error outranks a same-cycle fetch error.
REQ-027 Same-cycle store and fetch to the same word: fetch SHALL return pre-store contents (read-before-write); a store is visible to any load or fetch issued on a later edge.
REQ-028 Back-to-back accesses every cycle on both ports SHALL be supported with no stall; there is no ready/valid back-pressure.

Reset
REQ-029 While rst=0: isram_rdata=32'h0000_0013, dsram_rdata=0, err=0, err_code=0, err_addr=0, all asynchronously.
REQ-030 Memory contents are not reset; stores during reset are ignored.
REQ-031 Reset asserted mid-access SHALL discard that access; first edge after deassertion SHALL service requests normally.

Verification
REQ-032 Store dword 64'h1122334455667788 @BASE+0x10, sel=1000; load @BASE+0x10 next cycle -> dsram_rdata=64'h1122334455667788 one edge later.
REQ-033 Then store byte wdata=0xAB @BASE+0x13, sel=0001; load -> 64'h11223344AB667788; fetch @BASE+0x14 -> isram_rdata=32'h11223344.
REQ-034 Store half @BASE+0x11 (misaligned) -> memory unchanged, err=1, err_code=10, err_addr=BASE+0x11; later out-of-range load -> dsram_rdata=0, err_code stays 10.
REQ-035 Same edge: store word 0xDEADBEEF @BASE+0x20 and fetch @BASE+0x20 -> isram_rdata=old value; fetch next cycle -> 32'hDEADBEEF.
REQ-036 Fetch @BASE-4 -> isram_rdata=32'h00000013, err_code=01; assert rst mid-stream -> all outputs to reset values immediately, memory contents preserved.
